sha_round_sched: RTL
====================

Name: sha_round_sched

Overview:
- Round sequencer for the double-SHA-256 mining datapath.
- Steps the round counter, enable and sha-stage select that drive the KtWt adder and compression core, and supplies Kt from a constant ROM.
- Runs the stage-1 (sha_1) then stage-2 (sha_2) hash per nonce, and iterates nonces from a base over a requested count.
- Handshakes each finished hash out to the result collector.

Parameters:
- R1_START, 0: first round index of stage 1 (rounds below it are precomputed in midstate); legal range 0..8.
- NONCE_W, 32: nonce width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- nonce_base  in  NONCE_W  first nonce of the job; latched on accepted start
- nonce_count  in  NONCE_W  number of nonces to hash; latched on accepted start
- stall  in  1  freezes round advance in RUN1/RUN2
- abort  in  1  cancel the job
- hash_ready  in  1  collector accepts the hash
- r_cntr  out  6  current round index to KtWt/core
- en  out  1  round-valid strobe
- sha_sel  out  2  00 idle, 01 sha_1, 10 sha_2
- kt  out  32  K[r_cntr]
- load_state  out  1  core loads the initial state (midstate or IV)
- add_state  out  1  core performs the feed-forward addition
- nonce  out  NONCE_W  nonce currently being hashed
- hash_valid  out  1  stage-2 digest ready for the collector
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (rst==0 at posedge) takes effect regardless of state, including mid-round. Required values: state=IDLE, r_cntr=0, en=0, sha_sel=00, load_state=0, add_state=0, hash_valid=0, busy=0, done=0, nonce=0, remaining count=0.
- States: IDLE, LOAD1, RUN1, FIN1, LOAD2, RUN2, FIN2, DONE.
- IDLE:
  - start=1 latches nonce_base into nonce and nonce_count into remaining.
  - If nonce_count!=0, go to LOAD1; if nonce_count==0, go to DONE (no rounds).
- LOAD1: 1 cycle. load_state=1, sha_sel=01, r_cntr=R1_START, en=0. Next state RUN1.
- RUN1:
  - sha_sel=01, en = !stall.
  - If !stall: r_cntr increments; at r_cntr==63, go to FIN1.
  - If stall: r_cntr is held and en=0.
- FIN1: 1 cycle. add_state=1, sha_sel=01, en=0. Next state LOAD2.
- LOAD2: 1 cycle. load_state=1, sha_sel=10, r_cntr=0. Next state RUN2.
- RUN2: as RUN1 with sha_sel=10; at r_cntr==63 with !stall, go to FIN2.
- FIN2:
  - First cycle: add_state=1.
  - hash_valid=1 from the cycle after that first cycle; held stable (nonce unchanged) until hash_ready=1.
  - On hash_valid & hash_ready with remaining==1: go to DONE.
  - Otherwise: nonce <= nonce+1 (modulo 2^NONCE_W; 0xFFFFFFFF wraps to 0), remaining <= remaining-1, go to LOAD1.
- DONE: done=1 for exactly 1 cycle, busy=1; next state IDLE.
- kt = K[r_cntr], combinational from the registered r_cntr, so it is aligned with en in the same cycle.
- Latency per nonce with stall=0, hash_ready=1, R1_START=0:
  - LOAD1..FIN2 = 1+64+1+1+64+1 = 132 cycles; hash_valid is first asserted in cycle 133.
  - Stage 1 is shortened by R1_START cycles.
- Boundary and simultaneous events:
  - start while busy: ignored.
  - stall outside RUN1/RUN2: ignored.
  - abort in any non-IDLE state: next state IDLE, every output at its reset value except nonce (nonce retains its value), no done pulse. abort has priority over stall, hash_ready and the round-63 transition.
  - abort in IDLE: no effect.
  - start and abort together in IDLE: start is accepted.
  - hash_valid never drops without hash_ready, except on abort or reset.

Decomposition:
- Package sha_sched_pkg holds:
  - the state enum;
  - SHA_SEL_NONE/SHA_SEL_1/SHA_SEL_2 constants (00/01/10);
  - the 64-entry K constant array.
- One sub-module, kt_rom: 6-bit address in, 32-bit K out, purely combinational from the package array.
- The FSM, counters and nonce register stay in sha_round_sched.

Test Plan:
- Single nonce: nonce_base=0x00000010, nonce_count=1, stall=0, hash_ready=1 -> LOAD1 one cycle after start; hash_valid in cycle 133 with nonce=0x10; done the next cycle; busy low after done.
- Kt/rounds: during RUN1 -> r_cntr steps 0..63 contiguously with en=1; kt=0x428a2f98 at r_cntr=0 and 0xc67178f2 at r_cntr=63; sha_sel=01 in RUN1 and 10 in RUN2.
- Multi-nonce with wrap: nonce_base=0xFFFFFFFE, nonce_count=3 -> three hash_valid handshakes with nonce 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; exactly one done pulse.
- Stall and backpressure:
  - Stall 5 cycles at RUN2 r_cntr=20 -> r_cntr held at 20 and en=0 for 5 cycles; total latency grows to 137.
  - hash_ready low 4 cycles -> hash_valid and nonce held stable, then advance one cycle after hash_ready rises.
- Zero count and abort:
  - nonce_count=0 -> done one cycle after start; en, load_state and hash_valid never assert.
  - abort at RUN1 r_cntr=30 -> IDLE next cycle, no done pulse.
  - A following start with nonce_count=1 completes normally.
- Reset mid-operation: rst=0 at RUN2 r_cntr=40 -> all outputs at reset values on the next edge; a start issued after rst=1 produces the 132-cycle sequence.

Source files
------------

// File: rtl/sha_sched_pkg.sv
// ---------------------------------------------------------------------------
// sha_sched_pkg
// Shared definitions for the double-SHA-256 round sequencer.
//   - sched_state_t : sequencer state encoding
//   - SHA_SEL_*     : sha-stage select codes driven to the KtWt adder / core
//   - LAST_ROUND    : final round index of every SHA-256 stage
//   - K_TABLE       : the 64 SHA-256 round constants K[0..63]
//   - is_run_state  : helper, true in the two round-stepping states
// ---------------------------------------------------------------------------
package sha_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_RUN1  = 3'd2,
    ST_FIN1  = 3'd3,
    ST_LOAD2 = 3'd4,
    ST_RUN2  = 3'd5,
    ST_FIN2  = 3'd6,
    ST_DONE  = 3'd7
  } sched_state_t;

  localparam logic [1:0] SHA_SEL_NONE = 2'b00;
  localparam logic [1:0] SHA_SEL_1    = 2'b01;
  localparam logic [1:0] SHA_SEL_2    = 2'b10;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic is_run_state(input sched_state_t st);
    return (st == ST_RUN1) || (st == ST_RUN2);
  endfunction

endpackage

// File: rtl/sha_round_sched_kt_rom.sv
// ---------------------------------------------------------------------------
// kt_rom
// Combinational SHA-256 round-constant lookup.
// Ports:
//   i_addr [5:0]  round index
//   o_kt   [31:0] K[i_addr]
// Purely combinational so Kt lines up with the registered round counter in
// the same cycle it is presented to the KtWt adder.
// ---------------------------------------------------------------------------
module kt_rom
  import sha_sched_pkg::*;
(
  input  logic [5:0]  i_addr,
  output logic [31:0] o_kt
);

  assign o_kt = K_TABLE[i_addr];

endmodule

// File: rtl/sha_round_sched.sv
// ---------------------------------------------------------------------------
// sha_round_sched
// Round sequencer for the double-SHA-256 mining datapath. For each nonce of a
// job it runs stage 1 (rounds R1_START..63 on the midstate) and then stage 2
// (rounds 0..63 on the IV), then offers the digest to the result collector.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               begin a job (only looked at in IDLE)
//   nonce_base/_count   job description, latched on accepted start
//   stall               freezes round stepping in RUN1/RUN2
//   abort               cancels the job from any non-IDLE state
//   hash_ready          collector accepts the stage-2 digest
//   r_cntr, en, sha_sel round index, round-valid strobe, stage select
//   kt                  K[r_cntr]
//   load_state          core loads its initial state (midstate or IV)
//   add_state           core performs the feed-forward addition
//   nonce               nonce currently being hashed
//   hash_valid          stage-2 digest ready for the collector
//   busy, done          job in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module sha_round_sched
  import sha_sched_pkg::*;
#(
  parameter int R1_START = 0,
  parameter int NONCE_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_count,
  input  logic               stall,
  input  logic               abort,
  input  logic               hash_ready,
  output logic [5:0]         r_cntr,
  output logic               en,
  output logic [1:0]         sha_sel,
  output logic [31:0]        kt,
  output logic               load_state,
  output logic               add_state,
  output logic [NONCE_W-1:0] nonce,
  output logic               hash_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [5:0]         R1_FIRST = 6'(R1_START);
  localparam logic [NONCE_W-1:0] ONE_N    = {{(NONCE_W-1){1'b0}}, 1'b1};

  // Registered state
  sched_state_t       r_state;
  logic [5:0]         r_round;
  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_remaining;
  // Set from the second FIN2 cycle on: the first FIN2 cycle is the
  // feed-forward add, the digest is only valid after it.
  logic               r_hv;

  // Next-state values
  sched_state_t       w_state_next;
  logic [5:0]         w_round_next;
  logic [NONCE_W-1:0] w_nonce_next;
  logic [NONCE_W-1:0] w_remaining_next;
  logic               w_hv_next;
  logic               w_handshake;
  logic               w_accept_start;
  logic               w_step;

  assign w_accept_start = (r_state == ST_IDLE) && start;
  assign w_handshake    = (r_state == ST_FIN2) && r_hv && hash_ready;
  assign w_step         = is_run_state(r_state) && !stall;

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_round     <= 6'd0;
      r_nonce     <= '0;
      r_remaining <= '0;
      r_hv        <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_round     <= w_round_next;
      r_nonce     <= w_nonce_next;
      r_remaining <= w_remaining_next;
      r_hv        <= w_hv_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (nonce_count != '0) ? ST_LOAD1 : ST_DONE;
        end
      end
      ST_LOAD1: w_state_next = ST_RUN1;
      ST_RUN1: begin
        if (!stall && (r_round == LAST_ROUND)) begin
          w_state_next = ST_FIN1;
        end
      end
      ST_FIN1:  w_state_next = ST_LOAD2;
      ST_LOAD2: w_state_next = ST_RUN2;
      ST_RUN2: begin
        if (!stall && (r_round == LAST_ROUND)) begin
          w_state_next = ST_FIN2;
        end
      end
      ST_FIN2: begin
        if (w_handshake) begin
          w_state_next = (r_remaining == ONE_N) ? ST_DONE : ST_LOAD1;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase

    // Abort outranks every other transition, but IDLE ignores it so a
    // simultaneous start is still accepted.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    w_round_next     = r_round;
    w_nonce_next     = r_nonce;
    w_remaining_next = r_remaining;
    w_hv_next        = 1'b0;

    // 63 + 1 wraps to 0, which is also the value wanted in FIN.
    if (w_step) begin
      w_round_next = r_round + 6'd1;
    end

    // Destination-based overrides keep the counter correct on every
    // entry into a load state and clear it on any return to IDLE.
    case (w_state_next)
      ST_LOAD1: w_round_next = R1_FIRST;
      ST_LOAD2: w_round_next = 6'd0;
      ST_IDLE:  w_round_next = 6'd0;
      default:  ;
    endcase

    // hash_valid stays up until the handshake or an abort takes us out.
    w_hv_next = (r_state == ST_FIN2) && (w_state_next == ST_FIN2);

    if (w_accept_start) begin
      w_nonce_next     = nonce_base;
      w_remaining_next = nonce_count;
    end else if (abort && (r_state != ST_IDLE)) begin
      // The nonce is kept for debug visibility; the job itself is gone.
      w_remaining_next = '0;
    end else if (w_handshake) begin
      w_remaining_next = r_remaining - ONE_N;
      if (r_remaining != ONE_N) begin
        w_nonce_next = r_nonce + ONE_N;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from the registered state
  // -------------------------------------------------------------------------
  always_comb begin
    en         = 1'b0;
    sha_sel    = SHA_SEL_NONE;
    load_state = 1'b0;
    add_state  = 1'b0;
    hash_valid = 1'b0;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    case (r_state)
      ST_LOAD1: begin
        sha_sel    = SHA_SEL_1;
        load_state = 1'b1;
      end
      ST_RUN1: begin
        sha_sel = SHA_SEL_1;
        en      = !stall;
      end
      ST_FIN1: begin
        sha_sel   = SHA_SEL_1;
        add_state = 1'b1;
      end
      ST_LOAD2: begin
        sha_sel    = SHA_SEL_2;
        load_state = 1'b1;
      end
      ST_RUN2: begin
        sha_sel = SHA_SEL_2;
        en      = !stall;
      end
      ST_FIN2: begin
        sha_sel    = SHA_SEL_2;
        add_state  = !r_hv;
        hash_valid = r_hv;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign r_cntr = r_round;
  assign nonce  = r_nonce;

  kt_rom u_kt_rom (
    .i_addr (r_round),
    .o_kt   (kt)
  );

endmodule
